// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl
//   Loads a program into a byte-wide memory, one 32-bit instruction word at a
//   time. Each accepted word is written as four big-endian byte writes at
//   consecutive addresses. Every command is followed by an idle gap. When the
//   word flagged as last has been written, the core is started.
//
//   Optional feature (macro PROG_LOAD_VERIFY_EN): after each byte write and
//   its gap, the byte is read back at the same address and compared. A
//   mismatch ends in the error state.
//
// Parameters
//   CMD_WRITE    memory write command code
//   CMD_READ     memory read command code (issued only with PROG_LOAD_VERIFY_EN)
//   TIMEOUT_CYC  cycles a command may wait for cmd_done before erroring out
//   GAP_CYC      minimum idle cycles between commands
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   word_valid/ready/data/last  instruction word input handshake
//   cmd, cmd_valid, address, data_in  memory command outputs
//   data_out, cmd_done       memory read data and completion
//   run_stop                 one-cycle pulse: stop the core and rearm loading
//   start_signal             run enable to the core
//   busy                     load in progress
//   err                      sticky error flag (cleared only by rst)
module prog_load_ctrl #(
  parameter logic [7:0] CMD_WRITE   = 8'd2,
  parameter logic [7:0] CMD_READ    = 8'd1,
  parameter int         TIMEOUT_CYC = 255,
  parameter int         GAP_CYC     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic [31:0] word_data,
  input  logic        word_last,
  output logic [7:0]  cmd,
  output logic        cmd_valid,
  output logic [7:0]  address,
  output logic [7:0]  data_in,
  input  logic [7:0]  data_out,
  input  logic        cmd_done,
  input  logic        run_stop,
  output logic        start_signal,
  output logic        busy,
  output logic        err
);

  localparam int TO_M1  = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam int TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GAP_M1 = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
  localparam int GW     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GAP,
`ifdef PROG_LOAD_VERIFY_EN
    VFY_ISSUE,
    VFY_GAP,
`endif
    RUN,
    ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [6:0]    word_cnt_q, word_cnt_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   shift_q, shift_d;       // current byte always in [31:24]
  logic          last_q, last_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic full;
  logic gap_ok;
  logic tmo_hit;
  logic byte_fin;

  // 64 words fill the 256-byte space; bit 6 set means the count reached 64.
  assign full    = word_cnt_q[6];
  assign gap_ok  = (gap_cnt_q >= GW'(GAP_M1));
  assign tmo_hit = (tmo_cnt_q == TW'(TO_M1));

`ifndef PROG_LOAD_VERIFY_EN
  // Read path is not built in this configuration.
  logic unused_read_path;
  assign unused_read_path = ^{data_out, CMD_READ};
`endif

  // NOTE: every output and next-state value gets a default before the case,
  // so no path through the block leaves a signal unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    last_d     = last_q;
    gap_cnt_d  = '0;
    tmo_cnt_d  = '0;
    byte_fin   = 1'b0;
    word_ready = 1'b0;
    cmd        = '0;
    cmd_valid  = 1'b0;
    address    = '0;
    data_in    = '0;

    case (state_q)
      IDLE: begin
        // Held low while rst is asserted; rises once reset is released.
        word_ready = !full && !rst;
        if (word_valid && !full) begin
          shift_d    = word_data;
          last_d     = word_last;
          byte_idx_d = '0;
          word_cnt_d = word_cnt_q + 7'd1;
          state_d    = ISSUE;
        end else if (word_valid) begin
          state_d = ERROR;
        end
      end

      ISSUE: begin
        cmd       = CMD_WRITE;
        cmd_valid = 1'b1;
        address   = addr_q;
        data_in   = shift_q[31:24];
        if (cmd_done)     state_d = GAP;
        else if (tmo_hit) state_d = ERROR;
        else              tmo_cnt_d = tmo_cnt_q + TW'(1);
      end

      GAP: begin
        gap_cnt_d = gap_ok ? gap_cnt_q : gap_cnt_q + GW'(1);
        if (gap_ok && !cmd_done) begin
`ifdef PROG_LOAD_VERIFY_EN
          state_d = VFY_ISSUE;
`else
          byte_fin = 1'b1;
`endif
        end
      end

`ifdef PROG_LOAD_VERIFY_EN
      VFY_ISSUE: begin
        cmd       = CMD_READ;
        cmd_valid = 1'b1;
        address   = addr_q;
        if (cmd_done)     state_d = (data_out == shift_q[31:24]) ? VFY_GAP : ERROR;
        else if (tmo_hit) state_d = ERROR;
        else              tmo_cnt_d = tmo_cnt_q + TW'(1);
      end

      VFY_GAP: begin
        gap_cnt_d = gap_ok ? gap_cnt_q : gap_cnt_q + GW'(1);
        if (gap_ok && !cmd_done) byte_fin = 1'b1;
      end
`endif

      RUN: begin
        if (run_stop) begin
          addr_d     = '0;
          word_cnt_d = '0;
          state_d    = IDLE;
        end
      end

      ERROR: ;

      default: state_d = IDLE;
    endcase

    // A byte is fully done: step to the next address and the next byte,
    // or finish the word.
    if (byte_fin) begin
      addr_d     = addr_q + 8'd1;
      shift_d    = {shift_q[23:0], 8'h00};
      byte_idx_d = byte_idx_q + 2'd1;
      if (byte_idx_q == 2'd3) state_d = last_q ? RUN : IDLE;
      else                    state_d = ISSUE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      word_cnt_q <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      last_q     <= 1'b0;
      gap_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      gap_cnt_q  <= gap_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign start_signal = (state_q == RUN);
  assign err          = (state_q == ERROR);
  assign busy         = !(state_q == IDLE || state_q == RUN || state_q == ERROR);

endmodule

// File: tb/tb_prog_load_ctrl.sv
// tb_prog_load_ctrl
//   Self-checking bench for prog_load_ctrl. A behavioural memory answers
//   commands with random latency and random cmd_done hold time, logs every
//   completed write, and watches inter-command gaps and command stability.
//   Expected byte writes come from a queue built directly from the words sent.
module tb_prog_load_ctrl;

  localparam logic [7:0] CMD_WRITE   = 8'd2;
  localparam logic [7:0] CMD_READ    = 8'd1;
  localparam int         TIMEOUT_CYC = 255;
  localparam int         GAP_CYC     = 2;
`ifdef PROG_LOAD_VERIFY_EN
  localparam int VFY = 1;
`else
  localparam int VFY = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [31:0] word_data = '0;
  logic        word_last = 1'b0;
  logic [7:0]  cmd;
  logic        cmd_valid;
  logic [7:0]  address;
  logic [7:0]  data_in;
  logic [7:0]  data_out = '0;
  logic        cmd_done = 1'b0;
  logic        run_stop = 1'b0;
  logic        start_signal;
  logic        busy;
  logic        err;

  prog_load_ctrl #(
    .CMD_WRITE  (CMD_WRITE),
    .CMD_READ   (CMD_READ),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .GAP_CYC    (GAP_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .word_data   (word_data),
    .word_last   (word_last),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .address     (address),
    .data_in     (data_in),
    .data_out    (data_out),
    .cmd_done    (cmd_done),
    .run_stop    (run_stop),
    .start_signal(start_signal),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory model / monitor state
  logic [7:0] mem [256];
  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int   reads = 0;
  int   cmds = 0;
  int   gap_viol = 0;
  int   stab_viol = 0;
  int   valid_run = 0;
  int   idle_run = GAP_CYC;
  int   last_run = 0;
  int   lat_left = 0;
  int   hold_left = 0;
  bit   stall = 1'b0;
  bit   corrupt = 1'b0;
  logic [7:0] bad_addr = 8'd1;
  bit   start_seen = 1'b0;
  int   writes_at_start = 0;
  logic [7:0] cur_addr, cur_data, cur_cmd;

  // Reference model: expected byte writes in order
  logic [7:0] exp_addr[$];
  logic [7:0] exp_data[$];
  logic [7:0] model_addr = '0;

  always @(negedge clk) begin
    if (rst) begin
      cmd_done  = 1'b0;
      lat_left  = 0;
      hold_left = 0;
      valid_run = 0;
      idle_run  = GAP_CYC;
    end else begin
      if (cmd_valid) begin
        if (valid_run == 0) begin
          if (idle_run < GAP_CYC) gap_viol++;
          cur_addr = address;
          cur_data = data_in;
          cur_cmd  = cmd;
          cmds++;
        end else if (address != cur_addr || data_in != cur_data || cmd != cur_cmd) begin
          stab_viol++;
        end
        valid_run++;
        idle_run = 0;
      end else begin
        if (valid_run != 0) last_run = valid_run;
        valid_run = 0;
        idle_run++;
      end

      if (cmd_done) begin
        if (!cmd_valid) begin
          if (hold_left == 0) cmd_done = 1'b0;
          else hold_left--;
        end
      end else if (cmd_valid && !stall) begin
        if (lat_left == 0) begin
          cmd_done  = 1'b1;
          lat_left  = $urandom_range(0, 3);
          hold_left = $urandom_range(0, 2);
          if (cmd == CMD_WRITE) begin
            mem[address] = data_in;
            wr_addr_q.push_back(address);
            wr_data_q.push_back(data_in);
          end else if (cmd == CMD_READ) begin
            reads++;
            data_out = (corrupt && address == bad_addr) ? 8'hFF : mem[address];
          end
        end else begin
          lat_left--;
        end
      end

      if (start_signal && !start_seen) begin
        start_seen      = 1'b1;
        writes_at_start = wr_addr_q.size();
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    exp_addr.delete();
    exp_data.delete();
    reads = 0;
    start_seen = 1'b0;
    writes_at_start = 0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    int n = 0;
    @(negedge clk);
    while (!word_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("word_ready_wait", word_ready, 1'b1);
    word_valid = 1'b1;
    word_data  = w;
    word_last  = last;
    @(posedge clk);
    #1;
    word_valid = 1'b0;
    word_last  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_addr.push_back(model_addr);
      exp_data.push_back(8'((w >> (24 - 8 * k)) & 32'hFF));
      model_addr = model_addr + 8'd1;
    end
  endtask

  task automatic wait_start(input int bound);
    int n = 0;
    while (!start_signal && n < bound) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("start_signal", start_signal, 1'b1);
    check("busy_in_run", busy, 1'b0);
  endtask

  task automatic compare_log(input string tag);
    check($sformatf("%s_write_count", tag), wr_addr_q.size(), exp_addr.size());
    check($sformatf("%s_read_count", tag), reads, VFY * exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < wr_addr_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {wr_addr_q[i], wr_data_q[i]},
            {exp_addr[i], exp_data[i]});
  endtask

  task automatic pulse_run_stop();
    @(negedge clk);
    run_stop = 1'b1;
    @(posedge clk);
    #1;
    run_stop = 1'b0;
  endtask

  task automatic stop_and_rearm();
    pulse_run_stop();
    check("start_after_stop", start_signal, 1'b0);
    check("ready_after_stop", word_ready, 1'b1);
    model_addr = '0;
    clear_log();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    model_addr = '0;
    clear_log();
  endtask

  initial begin
    int n;
    int snap;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_word_ready", word_ready, 1'b0);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_outputs", {cmd, address, data_in}, 24'h0);
    check("rst_flags", {start_signal, busy, err}, 3'b000);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", word_ready, 1'b1);

    // Single last word
    send_word(32'h00500113, 1'b1);
    check("busy_loading", busy, 1'b1);
    wait_start(300);
    compare_log("one_word");

    // Three words; run_stop during loading is ignored
    stop_and_rearm();
    send_word(32'h00500113, 1'b0);
    pulse_run_stop();
    send_word(32'h00612193, 1'b0);
    send_word(32'h0031F213, 1'b1);
    wait_start(300);
    check("writes_before_start", writes_at_start, 12);
    compare_log("three_words");

    // run_stop then one word restarts at address 0
    stop_and_rearm();
    send_word(32'hDEADBEEF, 1'b1);
    wait_start(300);
    compare_log("restart");

    // Random programs
    for (int t = 0; t < 3; t++) begin
      stop_and_rearm();
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) send_word($urandom, i == n - 1);
      wait_start(300);
      compare_log($sformatf("rand%0d", t));
    end

    // Fill all 64 words without last, then offer one more
    stop_and_rearm();
    for (int i = 0; i < 64; i++) send_word($urandom, 1'b0);
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("full_idle", busy, 1'b0);
    check("full_ready_low", word_ready, 1'b0);
    check("full_no_err", {err, start_signal}, 2'b00);
    compare_log("full");
    @(negedge clk);
    word_valid = 1'b1;
    @(posedge clk);
    #1;
    word_valid = 1'b0;
    check("overflow_err", err, 1'b1);
    check("overflow_outputs", {cmd_valid, busy, start_signal, word_ready}, 4'b0000);

    // Timeout: memory never completes
    do_reset();
    check("err_cleared", err, 1'b0);
    stall = 1'b1;
    send_word(32'h00500113, 1'b1);
    n = 0;
    while (cmd_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("timeout_cycles", last_run, TIMEOUT_CYC);
    check("timeout_err", err, 1'b1);
    check("timeout_cmd_valid", cmd_valid, 1'b0);
    stall = 1'b0;
    snap = cmds;
    pulse_run_stop();
    repeat (20) @(negedge clk);
    check("error_sticky", err, 1'b1);
    check("error_no_cmds", cmds, snap);
    check("error_outputs", {cmd, address, data_in, start_signal, word_ready}, 26'h0);

    // Reset in the middle of byte 2 of word 0
    do_reset();
    send_word(32'h00500113, 1'b1);
    n = 0;
    while (!(cmd_valid && address == 8'd2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_byte2", address, 8'd2);
    #2 rst = 1'b1;
    #1;
    check("midrst_cmd_valid", cmd_valid, 1'b0);
    check("midrst_outputs", {cmd, address, data_in, busy, start_signal, word_ready}, 27'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    model_addr = '0;
    clear_log();
    @(posedge clk);
    #1;
    check("midrst_ready", word_ready, 1'b1);
    send_word(32'h0031F213, 1'b1);
    wait_start(300);
    compare_log("reload");

`ifdef PROG_LOAD_VERIFY_EN
    // Readback of address 1 returns 0xFF
    do_reset();
    corrupt = 1'b1;
    send_word(32'h00500113, 1'b1);
    n = 0;
    while (!err && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("vfy_err", err, 1'b1);
    check("vfy_writes", wr_addr_q.size(), 2);
    check("vfy_reads", reads, 2);
    snap = cmds;
    repeat (20) @(negedge clk);
    check("vfy_no_more_cmds", cmds, snap);
    check("vfy_outputs", {cmd_valid, start_signal}, 2'b00);
    corrupt = 1'b0;
`endif

    check("gap_violations", gap_viol, 0);
    check("stability_violations", stab_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
